// File: rtl/testchip_clk_pkg.sv
// Shared definitions for the test-chip clock block: sequencer states and
// test-clock mux source indices.
package testchip_clk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } sw_state_e;

    localparam int NUM_SRC = 9;

    localparam logic [3:0] NOC_CLK       = 4'd0;
    localparam logic [3:0] UC_CLK        = 4'd1;
    localparam logic [3:0] CDB_PCLK      = 4'd2;
    localparam logic [3:0] CMN_REFCLK0   = 4'd3;
    localparam logic [3:0] CMN_REFCLK1   = 4'd4;
    localparam logic [3:0] TCAUX0        = 4'd5;
    localparam logic [3:0] TCAUX1        = 4'd6;
    localparam logic [3:0] TEST_CLK_PHY  = 4'd7;
    localparam logic [3:0] TEST_CLK_PAM3 = 4'd8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/testchip_testclk_switch_ctrl.sv
// Glitch-free sequencer for the test-clock mux: gate, drain, switch select,
// settle, ungate. scanmode freezes the whole sequencer in place.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high unless in scan
// DRAIN  | output gated, waiting before the select moves
// SETTLE | select moved, waiting before the enable is restored
// DONE   | one-cycle completion, done pulse high
module testchip_testclk_switch_ctrl
    import testchip_clk_pkg::*;
#(
    parameter int NUM_SRC       = testchip_clk_pkg::NUM_SRC,
    parameter int SEL_W         = 4,
    parameter int DRAIN_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8,
    parameter int DEFAULT_SEL   = 0
) (
    input  logic             noc_clk,
    input  logic             noc_reset,
    input  logic             scanmode,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_en,
    output logic [SEL_W-1:0] test_clk_sel,
    output logic             test_clk_en,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       switch_cnt
);

    localparam logic [SEL_W-1:0] DEF_SEL     = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W+1)'(NUM_SRC);
    localparam logic [CNT_W-1:0] DRAIN_INIT  = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);

    sw_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic [SEL_W-1:0] lat_sel_q, lat_sel_d;
    logic             lat_en_q, lat_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       switch_cnt_q, switch_cnt_d;

    logic req_sel_oob;
    logic accept;

    assign req_sel_oob = {1'b0, req_sel} >= NUM_SRC_EXT;
    assign req_ready   = (state_q == IDLE) && !scanmode;
    assign accept      = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        en_d         = en_q;
        lat_sel_d    = lat_sel_q;
        lat_en_d     = lat_en_q;
        switch_cnt_d = switch_cnt_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        if (scanmode) begin
            // Frozen: pulses hold too, so nothing is lost across a scan window.
            done_d = done_q;
            err_d  = err_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_sel_oob) begin
                            err_d = 1'b1;
                        end else if (req_sel == sel_q) begin
                            en_d    = req_en;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            en_d      = 1'b0;
                            lat_sel_d = req_sel;
                            lat_en_d  = req_en;
                            cnt_d     = DRAIN_INIT;
                            state_d   = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        sel_d        = lat_sel_q;
                        switch_cnt_d = sat_inc8(switch_cnt_q);
                        cnt_d        = SETTLE_INIT;
                        state_d      = SETTLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        en_d    = lat_en_q;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge noc_clk) begin
        if (noc_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            sel_q        <= DEF_SEL;
            en_q         <= 1'b0;
            lat_sel_q    <= DEF_SEL;
            lat_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            switch_cnt_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            en_q         <= en_d;
            lat_sel_q    <= lat_sel_d;
            lat_en_q     <= lat_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign test_clk_sel = sel_q;
    assign test_clk_en  = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign switch_cnt   = switch_cnt_q;

endmodule

// File: tb/tb_testchip_testclk_switch_ctrl.sv
// Randomized bench for the test-clock switch sequencer against a timeline
// model: outputs are a function of active cycles elapsed since acceptance.
module tb_testchip_testclk_switch_ctrl;

    localparam int D    = 16;
    localparam int S    = 8;
    localparam int NSRC = 9;

    logic       noc_clk = 1'b0;
    logic       noc_reset;
    logic       scanmode;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_sel;
    logic       req_en;
    logic [3:0] test_clk_sel;
    logic       test_clk_en;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] switch_cnt;

    testchip_testclk_switch_ctrl dut (
        .noc_clk      (noc_clk),
        .noc_reset    (noc_reset),
        .scanmode     (scanmode),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sel      (req_sel),
        .req_en       (req_en),
        .test_clk_sel (test_clk_sel),
        .test_clk_en  (test_clk_en),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .switch_cnt   (switch_cnt)
    );

    always #5 noc_clk = ~noc_clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: what the mux currently sees.
    int m_sel = 0;
    int m_en  = 0;
    int m_cnt = 0;

    logic [16:0] obs;
    assign obs = {test_clk_sel, test_clk_en, done, busy, err, req_ready, switch_cnt};

    function automatic logic [16:0] exp_vec(int sel, int en, int dn, int bsy, int er, int rdy, int cnt);
        return {4'(sel), 1'(en), 1'(dn), 1'(bsy), 1'(er), 1'(rdy), 8'(cnt)};
    endfunction

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    // Select must never move while the output is enabled.
    logic [3:0] prev_sel;
    logic       prev_en = 1'b0;
    always @(posedge noc_clk) begin
        #1;
        if (prev_en && !noc_reset) begin
            n_checks++;
            if (test_clk_sel !== prev_sel) begin
                n_err++;
                $display("FAIL sel_while_enabled got=%0d expected=%0d", test_clk_sel, prev_sel);
            end
        end
        prev_sel = test_clk_sel;
        prev_en  = test_clk_en;
    end

    task automatic run_request(input int sel, input int en, input int freeze_at, input int freeze_len,
                               input bit hold, input int hsel, input int hen, input string tag);
        logic [16:0] e;
        int p, frz, old_sel, c0, c1;
        bit scan;
        req_valid = 1'b1;
        req_sel   = 4'(sel);
        req_en    = 1'(en);
        tick();
        if (hold) begin
            req_sel = 4'(hsel);
            req_en  = 1'(hen);
        end else begin
            req_valid = 1'b0;
        end

        if (sel >= NSRC) begin
            e = exp_vec(m_sel, m_en, 0, 0, 1, 1, m_cnt);
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL %s_err_pulse got=%h expected=%h", tag, obs, e); end
            tick();
            e = exp_vec(m_sel, m_en, 0, 0, 0, 1, m_cnt);
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL %s_err_clear got=%h expected=%h", tag, obs, e); end
        end else if (sel == m_sel) begin
            m_en = en;
            e = exp_vec(m_sel, m_en, 1, 1, 0, 0, m_cnt);
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL %s_same_done got=%h expected=%h", tag, obs, e); end
            tick();
            e = exp_vec(m_sel, m_en, 0, 0, 0, 1, m_cnt);
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL %s_same_idle got=%h expected=%h", tag, obs, e); end
        end else begin
            old_sel = m_sel;
            c0  = m_cnt;
            c1  = (c0 < 255) ? c0 + 1 : 255;
            p   = 0;
            frz = 0;
            e = exp_vec(old_sel, 0, 0, 1, 0, 0, c0);
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL %s_gate p=0 got=%h expected=%h", tag, obs, e); end
            for (int it = 0; it < D + S + 1 + freeze_len && p <= D + S; it++) begin
                scan = (freeze_len > 0) && (p == freeze_at) && (frz < freeze_len);
                scanmode = scan;
                tick();
                if (scan) frz++;
                else p++;
                e = exp_vec((p >= D) ? sel : old_sel,
                            (p >= D + S) ? en : 0,
                            (p == D + S) ? 1 : 0,
                            (p <= D + S) ? 1 : 0,
                            0,
                            (p > D + S && !scanmode) ? 1 : 0,
                            (p >= D) ? c1 : c0);
                n_checks++;
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL %s_seq p=%0d frz=%0d got=%h expected=%h", tag, p, frz, obs, e);
                end
            end
            scanmode = 1'b0;
            n_checks++;
            if (p != D + S + 1) begin
                n_err++;
                $display("FAIL %s_timeline_budget got=%0d expected=%0d", tag, p, D + S + 1);
            end
            m_sel = sel;
            m_en  = en;
            m_cnt = c1;
        end
    endtask

    task automatic test_reset();
        logic [16:0] e;
        noc_reset = 1'b1;
        tick();
        tick();
        noc_reset = 1'b0;
        tick();
        m_sel = 0; m_en = 0; m_cnt = 0;
        e = exp_vec(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== e) begin n_err++; $display("FAIL reset_state got=%h expected=%h", obs, e); end
    endtask

    task automatic test_reset_mid_settle();
        logic [16:0] e;
        req_valid = 1'b1; req_sel = 4'd6; req_en = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < D + 3; i++) tick();
        noc_reset = 1'b1;
        tick();
        noc_reset = 1'b0;
        m_sel = 0; m_en = 0; m_cnt = 0;
        e = exp_vec(0, 0, 0, 0, 0, 1, 0);
        n_checks++;
        if (obs !== e) begin n_err++; $display("FAIL reset_mid_settle got=%h expected=%h", obs, e); end
        for (int i = 0; i < 12; i++) begin
            tick();
            n_checks++;
            if (obs !== e) begin n_err++; $display("FAIL reset_no_done i=%0d got=%h expected=%h", i, obs, e); end
        end
    endtask

    task automatic test_random();
        int sel, en, fa, fl;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            en  = $urandom_range(0, 1);
            fa  = $urandom_range(0, D - 1);
            fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_request(sel, en, fa, fl, 1'b0, 0, 0, "random");
            for (int j = $urandom_range(0, 2); j > 0; j--) tick();
        end
    endtask

    task automatic test_saturation();
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = (m_sel + 1 + $urandom_range(0, NSRC - 2)) % NSRC;
            run_request(sel, $urandom_range(0, 1), 0, 0, 1'b0, 0, 0, "saturate");
        end
        n_checks++;
        if (switch_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL switch_cnt_saturated got=%0d expected=255", switch_cnt);
        end
    endtask

    initial begin
        noc_reset = 1'b1;
        scanmode  = 1'b0;
        req_valid = 1'b0;
        req_sel   = 4'd0;
        req_en    = 1'b0;

        test_reset();
        run_request(3, 1, 0, 0, 1'b0, 0, 0, "full_switch");
        run_request(9, 1, 0, 0, 1'b0, 0, 0, "invalid9");
        run_request(15, 0, 0, 0, 1'b0, 0, 0, "invalid15");
        run_request(3, 0, 0, 0, 1'b0, 0, 0, "same_sel");
        run_request(7, 1, 5, 10, 1'b0, 0, 0, "scan_freeze");
        test_reset_mid_settle();
        run_request(2, 1, 0, 0, 1'b1, 5, 1, "back_to_back_a");
        run_request(5, 1, 0, 0, 1'b0, 0, 0, "back_to_back_b");
        run_request(8, 0, 0, 0, 1'b0, 0, 0, "en_low_switch");
        test_random();
        test_saturation();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/testchip_testclk_switch_ctrl.md
Name: testchip_testclk_switch_ctrl

Overview:
- Sequencing controller in front of the test-clock mux block.
- Accepts select/enable change requests from the CSR/param layer and drives the mux's select and enable in a fixed order: gate the output, drain, switch the select, settle, ungate.
- Gives glitch-free source switching without firmware timing. Runs on noc_clk in the test-chip clock/reset block, replacing direct param drive of the mux select and enable.

Parameters:
- NUM_SRC, 9, number of valid mux sources; legal select values are 0..NUM_SRC-1.
- SEL_W, 4, select width.
- DRAIN_CYCLES, 16, noc_clk cycles the output is gated before the select changes; must be >=1.
- SETTLE_CYCLES, 8, noc_clk cycles after the select changes before ungating; must be >=1.
- CNT_W, 8, wait-counter width; must hold max(DRAIN_CYCLES, SETTLE_CYCLES)-1.
- DEFAULT_SEL, 0, select value applied at reset.

Ports:
- noc_clk  in  1  block clock.
- noc_reset  in  1  reset.
- scanmode  in  1  scan mode; freezes the sequencer.
- req_valid  in  1  request valid.
- req_ready  out  1  request accept.
- req_sel  in  SEL_W  requested source.
- req_en  in  1  requested enable after the switch.
- test_clk_sel  out  SEL_W  to mux select.
- test_clk_en  out  1  to mux enable.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  one-cycle pulse when a request is rejected.
- switch_cnt  out  8  saturating count of completed select changes.

Behaviour:
- Clocking and reset: single clock noc_clk. Reset noc_reset is synchronous, active-high.
- Reset values: state=IDLE, test_clk_sel=DEFAULT_SEL, test_clk_en=0, busy=0, done=0, err=0, switch_cnt=0, counter=0. All outputs are registered except req_ready.
- A reset in any state aborts the sequence immediately and forces the reset values. No done or err pulse is produced.
- Handshake:
  - req_ready = (state==IDLE) && !scanmode.
  - A request is accepted on a rising edge where req_valid && req_ready. req_sel and req_en are latched at that edge.
  - Requests that arrive while not ready are not queued. The requester holds req_valid.
- States: IDLE, DRAIN, SETTLE, DONE.
- IDLE, on accept, the first matching case applies:
  - req_sel >= NUM_SRC: err=1 for one cycle, outputs unchanged, stay IDLE.
  - req_sel == test_clk_sel: test_clk_en <= req_en, next state DONE. No drain or settle; switch_cnt unchanged.
  - Otherwise: test_clk_en <= 0, counter <= DRAIN_CYCLES-1, next state DRAIN.
- DRAIN:
  - Counter decrements each cycle.
  - When the counter reaches 0: test_clk_sel <= latched sel, switch_cnt increments (saturating at 255), counter <= SETTLE_CYCLES-1, next state SETTLE.
- SETTLE:
  - Counter decrements each cycle.
  - When the counter reaches 0: test_clk_en <= latched en, next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in DRAIN, SETTLE and DONE.
- Latency for a request accepted at edge k on the full path:
  - test_clk_en=0 after edge k.
  - test_clk_sel changes at edge k+DRAIN_CYCLES.
  - test_clk_en takes req_en at edge k+DRAIN_CYCLES+SETTLE_CYCLES.
  - done is high in the following cycle.
  - req_ready returns after edge k+DRAIN_CYCLES+SETTLE_CYCLES+1.
- Invariant: test_clk_sel never changes while test_clk_en=1.
- scanmode=1:
  - The FSM, counter and all outputs hold their current values and req_ready=0.
  - On deassertion the sequence resumes where it stopped.
- req_en=0 on a select change runs the full path and ends with test_clk_en=0.

Decomposition:
- Shared package testchip_clk_pkg holds:
  - the state enum (IDLE, DRAIN, SETTLE, DONE);
  - the test-clock source index constants (NOC_CLK=0, UC_CLK=1, CDB_PCLK=2, CMN_REFCLK0=3, CMN_REFCLK1=4, TCAUX0=5, TCAUX1=6, TEST_CLK_PHY=7, TEST_CLK_PAM3=8);
  - NUM_SRC.
- No sub-module. A single FSM plus down-counter is sufficient.

Test Plan:
- Reset, then idle -> sel=0, en=0, req_ready=1, switch_cnt=0.
- Request sel=3, en=1, accepted at edge k, defaults -> en=0 after k, sel=3 at k+16, en=1 at k+24, done pulse in cycle k+25, switch_cnt=1.
- Request sel=9, then sel=15 -> err pulse each time, sel and en unchanged, busy stays 0.
- Request equal to the current sel (3) with en=0 -> en=0 and done on the next cycle, switch_cnt stays 1.
- Assert scanmode mid-DRAIN for 10 cycles -> counter frozen, en stays 0, req_ready=0; completes 10 cycles late. Also assert noc_reset mid-SETTLE -> sel=DEFAULT_SEL, en=0, no done.
- Hold req_valid during a sequence with a second request -> not accepted until after done. Then run 300 switches -> switch_cnt saturates at 255.
